// File: rtl/glb_arb_pkg.sv
// Shared definitions for the GLB port arbiter.
// Contents:
//   GLB_ADDR_W / GLB_DATA_W  default GLB address and data widths
//   glb_req_t                one client's request bundle (we, addr, wdata) at the default widths
//   client_idx_w()           width of a client index (clog2 of the client count, minimum 1)
package glb_arb_pkg;

    localparam int GLB_ADDR_W = 20;
    localparam int GLB_DATA_W = 16;

    typedef struct packed {
        logic                  we;
        logic [GLB_ADDR_W-1:0] addr;
        logic [GLB_DATA_W-1:0] wdata;
    } glb_req_t;

    function automatic int client_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-find-first picker.
// The search starts at the client after ptr, wraps around, and picks the first
// client with its req bit set.
// Ports:
//   req    in   N       request vector
//   ptr    in   IDX_W   index of the most recently served client
//   grant  out  N       one-hot grant (all zero when nothing is requested)
//   idx    out  IDX_W   index of the granted client (0 when nothing is requested)
module rr_priority_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int  j;
        logic hit;
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!hit && req[j]) begin
                hit      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/glb_port_arbiter.sv
// Registered arbiter that multiplexes NUM_CLIENTS requesters onto one GLB port
// and routes read data back to the client that issued each read.
// A non-zero force_sel pins the port to its lowest set client (legacy one-hot
// behaviour); an all-zero force_sel selects round-robin arbitration.
// Optional feature macro: GLB_ARB_COLLISION_CNT_EN (saturating count of cycles
// with two or more requests; without it collision_count is tied to 0).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   force_sel        one-hot forced client select, zero = round-robin
//   req_valid/ready  per-client handshake (req_ready is combinational)
//   req_we           per-client 1 = write, 0 = read
//   req_addr/wdata   packed per-client address / write data
//   rsp_valid        one-cycle read-data-valid pulse to the issuing client
//   rsp_data         shared read-data bus, qualified by rsp_valid
//   glb_we/re        registered GLB write / read enables
//   glb_addr/wdata   registered GLB address / write data
//   glb_rdata        GLB read data
//   collision_count  contention statistic
module glb_port_arbiter
    import glb_arb_pkg::*;
#(
    parameter int NUM_CLIENTS  = 3,
    parameter int ADDR_WIDTH   = GLB_ADDR_W,
    parameter int DATA_WIDTH   = GLB_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            force_sel,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    input  logic [NUM_CLIENTS-1:0]            req_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              glb_we,
    output logic                              glb_re,
    output logic [ADDR_WIDTH-1:0]             glb_addr,
    output logic [DATA_WIDTH-1:0]             glb_wdata,
    input  logic [DATA_WIDTH-1:0]             glb_rdata,
    output logic [15:0]                       collision_count
);

    localparam int IDX_W = client_idx_w(NUM_CLIENTS);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_CLIENTS-1:0] rr_grant;
    logic [IDX_W-1:0]       rr_idx;
    logic [NUM_CLIENTS-1:0] force_grant;
    logic [IDX_W-1:0]       force_idx;
    logic                   force_mode;
    logic [IDX_W-1:0]       sel_idx;
    logic                   transfer;
    req_t                   sel_req;
    logic [NUM_CLIENTS-1:0] rd_tag;
    logic [NUM_CLIENTS-1:0] tag_pipe [READ_LATENCY];

    rr_priority_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Descending scan so the lowest set force_sel bit is the one that sticks.
    always_comb begin
        force_grant = '0;
        force_idx   = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (force_sel[i]) begin
                force_grant    = '0;
                force_grant[i] = 1'b1;
                force_idx      = IDX_W'(i);
            end
        end
    end

    assign force_mode = |force_sel;
    assign req_ready  = force_mode ? (force_grant & req_valid) : rr_grant;
    assign transfer   = |req_ready;
    assign sel_idx    = force_mode ? force_idx : rr_idx;

    always_comb begin
        sel_req.we    = req_we[sel_idx];
        sel_req.addr  = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_req.wdata = req_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Tag enters the pipe on the same edge that raises glb_re.
    assign rd_tag = (transfer && !sel_req.we) ? req_ready : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glb_we    <= 1'b0;
            glb_re    <= 1'b0;
            glb_addr  <= '0;
            glb_wdata <= '0;
            rr_ptr    <= IDX_W'(NUM_CLIENTS - 1);
            rsp_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            glb_we <= transfer & sel_req.we;
            glb_re <= transfer & ~sel_req.we;
            if (transfer) begin
                glb_addr  <= sel_req.addr;
                glb_wdata <= sel_req.wdata;
            end
            if (transfer && !force_mode) begin
                rr_ptr <= rr_idx;
            end
            tag_pipe[0] <= rd_tag;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            rsp_valid <= tag_pipe[READ_LATENCY-1];
        end
    end

    // Read data passes straight through; the bus reads 0 whenever no response is due.
    assign rsp_data = (|rsp_valid) ? glb_rdata : '0;

`ifdef GLB_ARB_COLLISION_CNT_EN
    logic [15:0] coll_cnt;
    logic        multi_req;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_req = |(req_valid & (req_valid - NUM_CLIENTS'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_cnt <= '0;
        end else if (multi_req && coll_cnt != 16'hFFFF) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end

    assign collision_count = coll_cnt;
`else
    assign collision_count = '0;
`endif

endmodule

// File: tb/tb_glb_port_arbiter.sv
module tb_glb_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    force_sel, req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   glb_rdata;

    logic [N-1:0]    ready1, rsp_valid1, ready3, rsp_valid3;
    logic [DW-1:0]   rsp_data1, wdata1, rsp_data3, wdata3;
    logic            we1, re1, we3, re3;
    logic [AW-1:0]   addr1, addr3;
    logic [15:0]     coll1, coll3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    glb_port_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(rst), .force_sel(force_sel), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
        .rsp_data(rsp_data1), .glb_we(we1), .glb_re(re1), .glb_addr(addr1), .glb_wdata(wdata1),
        .glb_rdata(glb_rdata), .collision_count(coll1));

    glb_port_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(rst), .force_sel(force_sel), .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
        .rsp_data(rsp_data3), .glb_we(we3), .glb_re(re3), .glb_addr(addr3), .glb_wdata(wdata3),
        .glb_rdata(glb_rdata), .collision_count(coll3));

    // Reference model: arbitration by the written rules, expected responses
    // scheduled by cycle number in associative arrays (one per read latency).
    int            cyc = 0;
    int            m_ptr = N - 1;
    logic          m_we, m_re;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_coll = 0;
    logic [N-1:0]  sched1 [int];
    logic [N-1:0]  sched3 [int];

    function automatic int model_grant();
        int g;
        g = -1;
        if (force_sel != '0) begin
            for (int i = 0; i < N; i++) if (g < 0 && force_sel[i]) g = i;
            if (!req_valid[g]) g = -1;
        end else begin
            for (int k = 1; k <= N; k++) if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        return g;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = N - 1; m_we = 1'b0; m_re = 1'b0; m_addr = '0; m_wdata = '0; m_coll = 0;
            sched1.delete();
            sched3.delete();
        end else begin
            int g;
            g = model_grant();
            cyc++;
`ifdef GLB_ARB_COLLISION_CNT_EN
            if ($countones(req_valid) >= 2 && m_coll < 65535) m_coll++;
`endif
            m_we = 1'b0;
            m_re = 1'b0;
            if (g >= 0) begin
                m_we    = req_we[g];
                m_re    = !req_we[g];
                m_addr  = req_addr[g*AW +: AW];
                m_wdata = req_wdata[g*DW +: DW];
                if (force_sel == '0) m_ptr = g;
                if (!req_we[g]) begin
                    sched1[cyc + 1] = N'(1) << g;
                    sched3[cyc + 3] = N'(1) << g;
                end
            end
        end
    end

    task automatic clear_inputs();
        force_sel = '0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_client(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({we1, re1, addr1, wdata1, rsp_valid1, rsp_data1, coll1, ready1} !== '0) begin
            n_err++;
            $display("FAIL reset_dut1 got we=%0b re=%0b addr=%h wdata=%h rsp=%b data=%h coll=%h rdy=%b want all 0",
                     we1, re1, addr1, wdata1, rsp_valid1, rsp_data1, coll1, ready1);
        end
        n_vec++;
        if ({we3, re3, addr3, wdata3, rsp_valid3, rsp_data3, coll3, ready3} !== '0) begin
            n_err++;
            $display("FAIL reset_dut3 got we=%0b re=%0b addr=%h wdata=%h rsp=%b data=%h coll=%h rdy=%b want all 0",
                     we3, re3, addr3, wdata3, rsp_valid3, rsp_data3, coll3, ready3);
        end
        rst = 1'b0;
    endtask

    task automatic test_forced();
        do_reset();
        @(negedge clk);
        force_sel = 3'b010; req_valid = 3'b111;
        set_client(0, 1'b0, AW'($urandom), DW'($urandom));
        set_client(1, 1'b0, 20'h00010, 16'h0000);
        set_client(2, 1'b1, AW'($urandom), DW'($urandom));
        #1;
        n_vec++;
        if (ready1 !== 3'b010 || ready3 !== 3'b010) begin
            n_err++; $display("FAIL forced_ready got %b/%b want 010", ready1, ready3);
        end
        @(negedge clk);
        clear_inputs();
        glb_rdata = 16'hA5C3;
        n_vec++;
        if ({re1, we1, addr1} !== {1'b1, 1'b0, 20'h00010}) begin
            n_err++; $display("FAIL forced_issue got re=%0b we=%0b addr=%h want re=1 we=0 addr=00010", re1, we1, addr1);
        end
        @(negedge clk);
        n_vec++;
        if (rsp_valid1 !== 3'b010 || rsp_data1 !== 16'hA5C3) begin
            n_err++; $display("FAIL forced_rsp got %b/%h want 010/a5c3", rsp_valid1, rsp_data1);
        end
        n_vec++;
        if (rsp_valid3 !== 3'b000) begin
            n_err++; $display("FAIL forced_rsp3_early got %b want 000", rsp_valid3);
        end
        @(negedge clk);
        force_sel = 3'b110; req_valid = 3'b111;
        #1;
        n_vec++;
        if (ready1 !== 3'b010) begin
            n_err++; $display("FAIL forced_multihot got %b want 010", ready1);
        end
        @(negedge clk);
        force_sel = 3'b100; req_valid = 3'b011;
        #1;
        n_vec++;
        if (ready1 !== 3'b000) begin
            n_err++; $display("FAIL forced_not_valid got %b want 000", ready1);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_rr_order();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            force_sel = '0; req_valid = 3'b111;
            for (int c = 0; c < N; c++) set_client(c, 1'b0, AW'($urandom), DW'($urandom));
            #1;
            n_vec++;
            if (ready1 !== (N'(1) << (k % 3)) || ready3 !== (N'(1) << (k % 3))) begin
                n_err++; $display("FAIL rr_order step %0d got %b/%b want %b", k, ready1, ready3, N'(1) << (k % 3));
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        req_valid = 3'b100;
        set_client(2, 1'b1, 20'h00005, 16'hBEEF);
        #1;
        n_vec++;
        if (ready1 !== 3'b100) begin
            n_err++; $display("FAIL write_ready got %b want 100", ready1);
        end
        @(negedge clk);
        clear_inputs();
        n_vec++;
        if ({we1, re1, addr1, wdata1} !== {1'b1, 1'b0, 20'h00005, 16'hBEEF}) begin
            n_err++; $display("FAIL write_issue got we=%0b re=%0b addr=%h wdata=%h want 1/0/00005/beef", we1, re1, addr1, wdata1);
        end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid1 !== '0 || rsp_valid3 !== '0 || we1 !== 1'b0 || addr1 !== 20'h00005 || wdata1 !== 16'hBEEF) begin
                n_err++;
                $display("FAIL write_idle cycle %0d got rsp=%b/%b we=%0b addr=%h wdata=%h want 000/000/0/00005/beef",
                         w, rsp_valid1, rsp_valid3, we1, addr1, wdata1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] e1, e3;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clear_inputs();
            req_valid = N'(1) << k;
            set_client(k, 1'b0, AW'($urandom), DW'($urandom));
        end
        for (int w = 3; w <= 7; w++) begin
            @(negedge clk);
            clear_inputs();
            e3 = (w >= 4 && w <= 6) ? (N'(1) << (w - 4)) : '0;
            e1 = (w <= 4) ? (N'(1) << (w - 2)) : '0;
            n_vec++;
            if (rsp_valid3 !== e3 || (e3 != '0 && rsp_data3 !== glb_rdata)) begin
                n_err++; $display("FAIL b2b_rl3 T+%0d got %b/%h want %b", w, rsp_valid3, rsp_data3, e3);
            end
            n_vec++;
            if (rsp_valid1 !== e1) begin
                n_err++; $display("FAIL b2b_rl1 T+%0d got %b want %b", w, rsp_valid1, e1);
            end
            glb_rdata = DW'($urandom);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        req_valid = 3'b010;
        set_client(1, 1'b0, 20'h00ABC, 16'h0000);
        @(negedge clk);
        clear_inputs();
        glb_rdata = 16'h5A5A;
        n_vec++;
        if (re1 !== 1'b1 || re3 !== 1'b1) begin
            n_err++; $display("FAIL async_issue got re=%0b/%0b want 1/1", re1, re3);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({we1, re1, addr1, wdata1, rsp_valid1, rsp_data1, we3, re3, addr3, wdata3, rsp_valid3, rsp_data3} !== '0) begin
            n_err++;
            $display("FAIL async_clear got re=%0b/%0b addr=%h/%h rsp=%b/%b want all 0", re1, re3, addr1, addr3, rsp_valid1, rsp_valid3);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid1 !== '0 || rsp_valid3 !== '0) begin
                n_err++; $display("FAIL async_no_rsp cycle %0d got %b/%b want 000/000", w, rsp_valid1, rsp_valid3);
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp_c;
`ifdef GLB_ARB_COLLISION_CNT_EN
        exp_c = 16'd5;
`else
        exp_c = 16'd0;
`endif
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 3'b011;
            set_client(0, 1'b0, AW'($urandom), DW'($urandom));
            set_client(1, 1'b1, AW'($urandom), DW'($urandom));
        end
        @(negedge clk);
        clear_inputs();
        n_vec++;
        if (coll1 !== exp_c || coll3 !== exp_c) begin
            n_err++; $display("FAIL collision_count got %h/%h want %h", coll1, coll3, exp_c);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] e1, e3, exp_rdy;
        int g, r;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            e1 = sched1.exists(cyc) ? sched1[cyc] : '0;
            e3 = sched3.exists(cyc) ? sched3[cyc] : '0;
            n_vec++;
            if ({we1, re1, addr1, wdata1} !== {m_we, m_re, m_addr, m_wdata} ||
                {we3, re3, addr3, wdata3} !== {m_we, m_re, m_addr, m_wdata}) begin
                n_err++;
                $display("FAIL rand_glb it %0d got we=%0b re=%0b addr=%h wd=%h (rl3 we=%0b re=%0b) want we=%0b re=%0b addr=%h wd=%h",
                         it, we1, re1, addr1, wdata1, we3, re3, m_we, m_re, m_addr, m_wdata);
            end
            n_vec++;
            if (rsp_valid1 !== e1 || rsp_data1 !== ((e1 != '0) ? glb_rdata : '0)) begin
                n_err++; $display("FAIL rand_rsp1 it %0d got %b/%h want %b", it, rsp_valid1, rsp_data1, e1);
            end
            n_vec++;
            if (rsp_valid3 !== e3 || rsp_data3 !== ((e3 != '0) ? glb_rdata : '0)) begin
                n_err++; $display("FAIL rand_rsp3 it %0d got %b/%h want %b", it, rsp_valid3, rsp_data3, e3);
            end
            n_vec++;
            if (coll1 !== 16'(m_coll) || coll3 !== 16'(m_coll)) begin
                n_err++; $display("FAIL rand_coll it %0d got %h/%h want %h", it, coll1, coll3, 16'(m_coll));
            end
            r = $urandom_range(0, 3);
            if (r == 2) force_sel = N'(1) << $urandom_range(0, N - 1);
            else if (r == 3) force_sel = N'($urandom_range(1, 7));
            else force_sel = '0;
            req_valid = N'($urandom_range(0, 7));
            for (int c = 0; c < N; c++) set_client(c, 1'($urandom), AW'($urandom), DW'($urandom));
            glb_rdata = DW'($urandom);
            #1;
            g = model_grant();
            exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
            n_vec++;
            if (ready1 !== exp_rdy || ready3 !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready it %0d fs=%b v=%b got %b/%b want %b", it, force_sel, req_valid, ready1, ready3, exp_rdy);
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        glb_rdata = 16'h1234;
        test_reset();
        test_forced();
        test_rr_order();
        test_write();
        test_back_to_back();
        test_async_reset();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
